// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default widths
// and the width helper used to size requester indices.
package uart_pkg;

   localparam int unsigned NbDataDefault = 8;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StStart    = 2'd1,
      StWaitDone = 2'd2,
      StGap      = 2'd3
   } arb_state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request strictly after the last grant,
// wrapping modulo N. Reusable for any shared resource.
module rr_priority_pick
   import uart_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned NB_ID = clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [NB_ID-1:0] last_i,
   output logic [NB_ID-1:0] idx_o,
   output logic             valid_o
);

   localparam int Ni = int'(N);

   // Walk from farthest to nearest so the nearest set bit is the last write.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int k = Ni; k >= 1; k--) begin
         if (req_i[(int'(last_i) + k) % Ni]) begin
            idx_o   = NB_ID'((int'(last_i) + k) % Ni);
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte producers, with a
// baud-tick timed idle gap after each frame.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned NB_DATA   = NbDataDefault,
   parameter int unsigned GAP_TICKS = 16,
   parameter int unsigned NB_GAP    = 5
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic [N_REQ-1:0]           i_req,
   input  logic [N_REQ*NB_DATA-1:0]   i_data,
   output logic [N_REQ-1:0]           o_ack,
   input  logic                       i_tick,
   output logic                       o_tx_start,
   output logic [NB_DATA-1:0]         o_tx_data,
   input  logic                       i_tx_done,
   output logic [clog2(N_REQ)-1:0]    o_grant_id,
   output logic                       o_busy
);

   localparam int unsigned NB_ID = clog2(N_REQ);
   localparam logic [NB_GAP-1:0] GapLast = NB_GAP'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

   arb_state_e         state_q, state_d;
   logic [NB_GAP-1:0]  gap_q, gap_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               start_q, start_d;
   logic [NB_DATA-1:0] data_q, data_d;
   logic [NB_ID-1:0]   grant_q, grant_d;
   logic               busy_q, busy_d;
   logic [NB_ID-1:0]   pick_idx;
   logic               pick_valid;

   rr_priority_pick #(
      .N     (N_REQ),
      .NB_ID (NB_ID)
   ) u_pick (
      .req_i   (i_req),
      .last_i  (grant_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= StIdle;
         gap_q   <= '0;
         ack_q   <= '0;
         start_q <= 1'b0;
         data_q  <= '0;
         grant_q <= NB_ID'(N_REQ - 1);
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         ack_q   <= ack_d;
         start_q <= start_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:     if (pick_valid) state_d = StStart;
         StStart:    state_d = StWaitDone;
         StWaitDone: if (i_tx_done) state_d = (GAP_TICKS == 0) ? StIdle : StGap;
         StGap:      if (i_tick && gap_q == GapLast) state_d = StIdle;
         default:    state_d = StIdle;
      endcase
   end

   // Registered outputs: computed here as next values, so each lands one cycle after its cause.
   always_comb begin
      ack_d   = '0;
      start_d = (state_q == StStart);
      data_d  = data_q;
      grant_d = grant_q;
      busy_d  = (state_d != StIdle);
      gap_d   = gap_q;
      if (state_q == StIdle && pick_valid) begin
         ack_d[pick_idx] = 1'b1;
         data_d          = i_data[int'(pick_idx)*NB_DATA +: NB_DATA];
         grant_d         = pick_idx;
      end
      if (state_q == StWaitDone) gap_d = '0;
      if (state_q == StGap && i_tick) gap_d = (gap_q == GapLast) ? '0 : gap_q + 1'b1;
   end

   assign o_ack      = ack_q;
   assign o_tx_start = start_q;
   assign o_tx_data  = data_q;
   assign o_grant_id = grant_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: cycle table against a GAP_TICKS=0 instance, hand sequences for
// gap timing, fairness, withdrawal and reset against a GAP_TICKS=16 instance.
module tb_uart_tx_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // GAP_TICKS=16 instance
   logic [3:0]  req = '0;
   logic [31:0] data = '0;
   logic        tick = 1'b0, done = 1'b0;
   logic [3:0]  ack;
   logic        start, busy;
   logic [7:0]  tdata;
   logic [1:0]  grant;

   // GAP_TICKS=0 instance
   logic [3:0]  req0 = '0;
   logic [31:0] data0 = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
   logic        tick0 = 1'b0, done0 = 1'b0;
   logic [3:0]  ack0;
   logic        start0, busy0;
   logic [7:0]  tdata0;
   logic [1:0]  grant0;

   int n_vec = 0;
   int n_bad = 0;

   uart_tx_arbiter #(.N_REQ(4), .NB_DATA(8), .GAP_TICKS(16), .NB_GAP(5)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_data(data), .o_ack(ack),
      .i_tick(tick), .o_tx_start(start), .o_tx_data(tdata), .i_tx_done(done),
      .o_grant_id(grant), .o_busy(busy)
   );

   uart_tx_arbiter #(.N_REQ(4), .NB_DATA(8), .GAP_TICKS(0), .NB_GAP(5)) dut0 (
      .i_clk(clk), .i_reset_n(rst_n), .i_req(req0), .i_data(data0), .o_ack(ack0),
      .i_tick(tick0), .o_tx_start(start0), .o_tx_data(tdata0), .i_tx_done(done0),
      .o_grant_id(grant0), .o_busy(busy0)
   );

   typedef struct packed {
      logic [3:0] req;
      logic       done;
      logic [3:0] ack;
      logic       start;
      logic       busy;
      logic [1:0] grant;
      logic [7:0] data;
   } vec_t;

   vec_t tbl [14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One full frame on the gap-16 instance, entered from IDLE with the winner pending.
   task automatic do_frame(input int id, input logic [7:0] d, input bit coinc, input bit stray,
                           input logic [3:0] req_mid);
      step();
      chk($sformatf("ack id%0d", id), {ack, start, busy, grant, tdata},
          {4'(1 << id), 1'b0, 1'b1, 2'(id), d});
      req = req_mid;
      if (stray) done = 1'b1;
      step();
      done = 1'b0;
      chk("tx_start pulse", {ack, start, busy}, {4'b0000, 1'b1, 1'b1});
      if (stray) begin
         for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
         end
      end
      step();
      done = 1'b1;
      if (coinc) tick = 1'b1;
      step();
      done = 1'b0;
      tick = 1'b0;
      chk("gap entered", {start, busy}, {1'b0, 1'b1});
      for (int t = 0; t < 16; t++) begin
         tick = 1'b1;
         if (t == 5) done = 1'b1;
         step();
         tick = 1'b0;
         done = 1'b0;
         if (t == 14) chk("gap hold after 15 ticks", {ack, busy}, {4'b0000, 1'b1});
         if (t < 15) step();
      end
      chk("gap end idle", {ack, busy, start}, {4'b0000, 1'b0, 1'b0});
   endtask

   initial begin
      tbl[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3, 8'h00};
      tbl[1]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hB0};
      tbl[2]  = '{4'b0101, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'hB0};
      tbl[3]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'hB0};
      tbl[4]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hB0};
      tbl[5]  = '{4'b0101, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2, 8'hB2};
      tbl[6]  = '{4'b0101, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 8'hB2};
      tbl[7]  = '{4'b0101, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hB2};
      tbl[8]  = '{4'b0101, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hB2};
      tbl[9]  = '{4'b0101, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hB0};
      tbl[10] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 8'hB0};
      tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hB0};
      tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hB0};
      tbl[13] = '{4'b1000, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 8'hB3};

      step();
      step();
      chk("reset outputs", {ack, start, busy, grant, tdata}, {4'b0000, 1'b0, 1'b0, 2'd3, 8'h00});
      rst_n = 1'b1;

      // GAP_TICKS=0 cycle table
      for (int i = 0; i < 14; i++) begin
         req0  = tbl[i].req;
         done0 = tbl[i].done;
         step();
         chk($sformatf("gap0 vec%0d", i), {ack0, start0, busy0, grant0, tdata0},
             {tbl[i].ack, tbl[i].start, tbl[i].busy, tbl[i].grant, tbl[i].data});
      end
      req0  = '0;
      done0 = 1'b0;

      // Round robin with all four held; frame 2 has tick coincident with done,
      // frame 3 has a stray done in START followed by ticks in WAIT_DONE.
      data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         do_frame(i % 4, 8'hA0 + 8'(i % 4), i == 2, i == 3, 4'b1111);
      end

      // Withdrawal: requester 2 loses to 1, then drops before it can be served.
      req = 4'b0110;
      do_frame(1, 8'hA1, 1'b0, 1'b0, 4'b1000);
      do_frame(3, 8'hA3, 1'b0, 1'b0, 4'b1000);

      // Reset in the middle of WAIT_DONE.
      req = 4'b0001;
      step();
      chk("pre-reset ack", {ack, grant, tdata}, {4'b0001, 2'd0, 8'hA0});
      step();
      chk("pre-reset start", start, 1'b1);
      step();
      rst_n = 1'b0;
      #1;
      chk("async reset", {ack, start, busy, grant, tdata}, {4'b0000, 1'b0, 1'b0, 2'd3, 8'h00});
      step();
      chk("held in reset", {ack, start, busy}, {4'b0000, 1'b0, 1'b0});
      rst_n = 1'b1;
      step();
      chk("post-reset ack", {ack, start, busy, grant, tdata}, {4'b0001, 1'b0, 1'b1, 2'd0, 8'hA0});
      step();
      chk("post-reset start", {ack, start, busy}, {4'b0000, 1'b1, 1'b1});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among N_REQ byte producers using round-robin arbitration. The block sequences each frame through start, completion and an inter-frame guard gap. The gap is timed in baud ticks from the baud-rate generator. It sits between the client logic (command decoder, status reporter, etc.) and the UART TX datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
NB_DATA, 8, data width per request
GAP_TICKS, 16, baud ticks of idle line enforced after each frame (0 = no gap)
NB_GAP, 5, gap counter width; must hold GAP_TICKS-1

Ports:
i_clk  in  1  system clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_req  in  N_REQ  level request per requester; held until acked
i_data  in  N_REQ*NB_DATA  requester k byte at [k*NB_DATA +: NB_DATA]
o_ack  out  N_REQ  one-cycle pulse to the winner when its byte is latched
i_tick  in  1  baud tick from baud-rate generator (one-cycle pulse)
o_tx_start  out  1  one-cycle start pulse to UART TX
o_tx_data  out  NB_DATA  latched byte; stable from ack until next grant
i_tx_done  in  1  one-cycle pulse from UART TX at end of stop bit
o_grant_id  out  clog2(N_REQ)  index of current or last winner
o_busy  out  1  high in any state except IDLE

Behaviour:
- One clock domain. Reset is asynchronous and active-low: i_reset_n low clears all state immediately. All outputs are registered.
- Reset values:
  - state=IDLE
  - o_ack=0, o_tx_start=0, o_tx_data=0, o_busy=0
  - o_grant_id=N_REQ-1, so requester 0 has first priority
  - gap counter=0
- FSM states: IDLE, START, WAIT_DONE, GAP.
- IDLE:
  - If any i_req bit is high at edge n, select the first set bit searching from o_grant_id+1 upward, wrapping modulo N_REQ.
  - At edge n: latch that requester's byte into o_tx_data, load o_grant_id, pulse o_ack[winner] for one cycle, set o_busy, go to START.
  - If no request: stay in IDLE.
- START: o_tx_start=1 for exactly one cycle, then go to WAIT_DONE. i_tx_done is ignored here.
- WAIT_DONE:
  - Hold until i_tx_done=1.
  - On i_tx_done, go to GAP with counter=0, or to IDLE if GAP_TICKS=0.
  - i_tick is ignored in this state, including a tick coincident with done.
- GAP:
  - Counter increments on each i_tick.
  - When i_tick arrives with counter==GAP_TICKS-1, go to IDLE and clear the counter.
  - Requests are not sampled in GAP.
- Latency: request sampled in IDLE → ack 1 cycle later → tx_start 2 cycles later. Minimum request-to-request spacing is frame time plus GAP_TICKS ticks plus 1 cycle.
- Fairness: a requester that keeps i_req high cannot win twice while another requester is pending.
- A requester dropping i_req after being acked has no effect. Dropping i_req before being acked withdraws the request.
- Stray i_tx_done pulses in IDLE or GAP are ignored.
- Reset asserted mid-frame aborts the sequence with no further tx_start. The UART TX is reset by the same signal.

Decomposition:
- Shared uart_pkg:
  - FSM state encoding (2-bit localparams)
  - default NB_DATA
  - the clog2 helper used for o_grant_id width
- One sub-module: rr_priority_pick. This is a combinational rotate-and-find-first that takes the request vector and last grant, and returns the winner index plus a valid flag. It is reusable for other shared resources.

Test Plan:
1. Reset value check: assert i_reset_n=0 mid-WAIT_DONE → all outputs read 0 immediately, o_grant_id=N_REQ-1. Release reset and raise i_req=4'b0001 → o_ack=0001 one cycle later, then o_tx_start pulse, o_tx_data = requester 0 byte.
2. Round-robin order: all four requesters held high with bytes 8'hA0..8'hA3, GAP_TICKS=16 → four frames sent in order A0, A1, A2, A3, then A0; o_grant_id sequence 0,1,2,3,0.
3. Gap timing: after i_tx_done, count ticks → next o_tx_start occurs only after the 16th i_tick plus 2 cycles. A request raised during GAP is not acked before then.
4. Simultaneous and stray events: i_tick coincident with i_tx_done → gap still requires 16 further ticks. i_tx_done pulsed during START or IDLE → no state change.
5. Withdrawal: i_req[2] pulsed high then low while busy with requester 1 → requester 2 is never acked; next grant goes to the next pending index.
6. GAP_TICKS=0 configuration: back-to-back requests → tx_start re-asserts 2 cycles after i_tx_done; o_busy drops for exactly 1 cycle (IDLE).
